// File: rtl/systolic_pkg.sv
// Shared types and requester indices for the systolic tile memory path.
package systolic_pkg;

    typedef enum logic [0:0] {
        ARB,
        BURST
    } arb_state_t;

    localparam int unsigned REQ_A = 0;
    localparam int unsigned REQ_B = 1;
    localparam int unsigned REQ_C = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] winner,
    output logic                 any_valid
);

    int unsigned idx;

    always_comb begin
        winner    = '0;
        any_valid = |req;
        idx       = 0;
        // Scan from the far end so the candidate closest to ptr is written last and wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (32'(ptr) + 32'(off)) % NUM_REQ;
            if (req[idx]) begin
                winner = IDX_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/tile_mem_arbiter.sv
// Round-robin burst arbiter sharing one single-port tile SRAM between fetch/store engines.
module tile_mem_arbiter
    import systolic_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_last,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            proto_err
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    arb_state_t            state;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        next_ptr;
    logic [IDW-1:0]        pick_idx;
    logic                  pick_any;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic                  burst_wr;
    logic                  in_burst;
    logic                  grant_live;
    logic                  access;
    logic                  last_beat;
    logic                  rsp_pend;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_last_q;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDW)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .winner    (pick_idx),
        .any_valid (pick_any)
    );

    assign in_burst   = (state == BURST);
    assign grant_live = req_valid[grant_id];
    assign access     = in_burst && grant_live;
    assign last_beat  = (beat_cnt == burst_len);
    assign busy       = in_burst;
    assign proto_err  = in_burst && !grant_live;
    assign next_ptr   = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        mem_en    = access;
        mem_we    = access && burst_wr;
        mem_addr  = '0;
        mem_wdata = '0;
        if (access) begin
            req_ready[grant_id] = 1'b1;
            mem_addr            = base_addr + ADDR_WIDTH'(beat_cnt);
            mem_wdata           = req_wdata[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            rr_ptr    <= '0;
            grant_id  <= '0;
            base_addr <= '0;
            burst_len <= '0;
            burst_wr  <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (pick_any) begin
                        state     <= BURST;
                        grant_id  <= pick_idx;
                        base_addr <= req_addr[32'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        burst_len <= req_len[32'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
                        burst_wr  <= req_write[pick_idx];
                        beat_cnt  <= '0;
                    end
                end
                BURST: begin
                    // An abort (requester dropped) ends the burst like a last beat.
                    if (!grant_live || last_beat) begin
                        state  <= ARB;
                        rr_ptr <= next_ptr;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Response pipe tags its own requester so it can overlap the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend   <= 1'b0;
            rsp_id     <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            rsp_pend   <= access && !burst_wr;
            rsp_id     <= grant_id;
            rsp_last_q <= last_beat;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_pend) begin
            rsp_valid[rsp_id] = 1'b1;
        end
    end

    assign rsp_data = rsp_pend ? mem_rdata : '0;
    assign rsp_last = rsp_pend && rsp_last_q;

endmodule

// File: doc/tile_mem_arbiter.md
Name: tile_mem_arbiter

Overview:
- Shares one single-port tile SRAM between NUM_REQ requesters. Ports: 0 = activation fetch (A read), 1 = weight fetch (B read), 2 = result store (C write).
- Sits between the systolic controller's fetch/store engines and the SRAM macro.
- Grants whole bursts round-robin, generates sequential burst addresses, and routes 1-cycle-latency read data back to the granted requester.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_WIDTH, 10, SRAM word address width
DATA_WIDTH, 32, SRAM word width
LEN_WIDTH, 4, burst length field width (beats = req_len+1, max 16)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester burst request, held high until last beat accepted
req_write  input  NUM_REQ  1 = write burst, 0 = read burst
req_addr  input  NUM_REQ*ADDR_WIDTH  burst base address, packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_len  input  NUM_REQ*LEN_WIDTH  beats minus one, packed
req_wdata  input  NUM_REQ*DATA_WIDTH  write data for current beat, packed
req_ready  output  NUM_REQ  beat accepted this cycle (one-hot or zero)
rsp_valid  output  NUM_REQ  read data valid for requester i (one-hot or zero)
rsp_data  output  DATA_WIDTH  read data, shared bus
rsp_last  output  1  qualifies final read beat of a burst
mem_en  output  1  SRAM access enable
mem_we  output  1  SRAM write enable
mem_addr  output  ADDR_WIDTH  SRAM address
mem_wdata  output  DATA_WIDTH  SRAM write data
mem_rdata  input  DATA_WIDTH  SRAM read data, valid cycle after mem_en&&!mem_we
grant_id  output  $clog2(NUM_REQ)  current/last granted requester
busy  output  1  burst in progress
proto_err  output  1  one-cycle pulse on burst abort

Behaviour:
- Reset: all outputs 0; rr pointer 0; state ARB; in-flight read response discarded.
- FSM states: ARB, BURST.
- ARB: if any req_valid, pick first asserted index at or after rr pointer (wrapping); register winner into grant_id; latch its addr, len, write; beat_cnt = 0; go BURST. No requests: stay ARB, mem_en = 0.
- BURST, per cycle: mem_en = 1, mem_we = latched write, mem_addr = base + beat_cnt (mod 2^ADDR_WIDTH, wraps 1023 -> 0), mem_wdata = granted req_wdata, req_ready[grant_id] = 1; beat_cnt++.
- Outputs in BURST are combinational from state/counters; req_ready and the memory strobes are the same cycle.
- Last beat (beat_cnt == len): rr pointer = grant_id+1 mod NUM_REQ; busy drops next cycle; return to ARB.
- Arbitration gap: exactly one idle cycle between bursts. Grant-decision latency: request seen in ARB cycle t, first mem_en at t+1.
- Read response: registered. rsp_valid[g] = 1 and rsp_data = mem_rdata one cycle after each read beat; rsp_last = 1 with final beat. No response backpressure.
- Read responses of a burst may overlap the next burst's ARB cycle or first beat; the response pipeline carries its own requester id, not grant_id.
- Abort: req_valid[grant_id] low during BURST.
  - That cycle: no access (mem_en = 0, no ready); proto_err pulses; return to ARB.
  - rr pointer still advances.
  - Responses for already-issued reads are still delivered; rsp_last is not asserted.
- Changes to req_addr/len/write during a burst are ignored (latched at grant).
- busy = (state == BURST).
- Reset asserted mid-burst: immediate return to reset values; no further mem_en.

Decomposition:
- systolic_pkg: arb_state_t enum {ARB, BURST}; REQ_A=0, REQ_B=1, REQ_C=2 index constants.
- One sub-module: rr_pick, purely combinational.
  - Inputs: req vector, pointer.
  - Outputs: winner index, any_valid.
  - Reused by future multi-bank arbiters.

Test Plan:
- Single read: req_valid[0], addr 0x010, len 3, SRAM preloaded with 0xA0..0xA3 -> mem_addr 0x010..0x013 on cycles t+1..t+4; rsp_valid[0] at t+2..t+5 with data 0xA0..0xA3; rsp_last at t+5 only; busy high 4 cycles.
- All three request simultaneously, len 0 each, pointer 0 -> grants 0,1,2 in order, one ARB cycle between. Then requesters 1 and 2 re-request -> order 1 then 2, i.e. pointer honoured.
- Write burst: req 2, addr 0x100, len 1, wdata 0x11111111 then 0x22222222 after first ready -> SRAM 0x100 = 0x11111111, 0x101 = 0x22222222; no rsp_valid.
- Address wrap: read addr 0x3FE, len 3 -> mem_addr 0x3FE, 0x3FF, 0x000, 0x001.
- Abort: read len 7, drop req_valid after 3 beats -> proto_err one cycle; 3 rsp_valid beats, no rsp_last; next requester granted after one ARB cycle.
- Reset mid-burst: assert rst_n low during beat 2 of a read -> mem_en, req_ready, rsp_valid, busy 0 immediately. After release, first grant goes to the lowest-index requesting port (pointer 0).
